// File: rtl/sq_gen_pkg.sv
// Shared types and constants for the sq_gen square-wave generator.
// Optional burst mode is enabled by defining SQ_GEN_BURST_EN.
package sq_gen_pkg;

  localparam int unsigned CNT_W      = 28;
  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned MIN_HIGH   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } cfg_t;

  // Force at least one high and one low cycle per period.
  function automatic cfg_t cfg_clamp(input cfg_t c);
    cfg_t r;
    r.period = (c.period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : c.period;
    if (c.high < CNT_W'(MIN_HIGH)) begin
      r.high = CNT_W'(MIN_HIGH);
    end else if (c.high >= r.period) begin
      r.high = r.period - CNT_W'(1);
    end else begin
      r.high = c.high;
    end
    return r;
  endfunction

endpackage

// File: rtl/sq_gen_if.sv
// Control/status bundle of sq_gen; burst signals exist only with SQ_GEN_BURST_EN.
interface sq_gen_if;
  import sq_gen_pkg::*;

  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             square;
  logic             period_done;
  logic [CNT_W-1:0] period_cnt;
  logic             busy;
`ifdef SQ_GEN_BURST_EN
  logic [CNT_W-1:0] burst_len;
  logic             burst_done;
`endif

  modport slave (
    input  en, cfg_valid, cfg_period, cfg_high,
`ifdef SQ_GEN_BURST_EN
    input  burst_len,
    output burst_done,
`endif
    output cfg_ready, square, period_done, period_cnt, busy
  );

  modport master (
    output en, cfg_valid, cfg_period, cfg_high,
`ifdef SQ_GEN_BURST_EN
    output burst_len,
    input  burst_done,
`endif
    input  cfg_ready, square, period_done, period_cnt, busy
  );

endinterface

// File: rtl/sq_gen_cfg_reg.sv
// Shadow/active configuration registers: clamps on capture, copies shadow to
// active when the parent strobes i_apply at a period boundary.
module sq_gen_cfg_reg
  import sq_gen_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(6),
  parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(3)
) (
  input  logic clk_6M,
  input  logic rst_n,
  input  logic i_cfg_valid,
  input  cfg_t i_cfg,
  input  logic i_apply,
  output logic o_cfg_ready,
  output cfg_t o_active
);

  cfg_t r_shadow;
  cfg_t r_active;
  logic r_pending;
  logic w_capture;

  assign w_capture = i_cfg_valid & ~r_pending;

  // A capture can only happen with pending clear, so it never races an apply.
  always_ff @(posedge clk_6M or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '{period: DEF_PERIOD, high: DEF_HIGH};
      r_active  <= '{period: DEF_PERIOD, high: DEF_HIGH};
      r_pending <= 1'b0;
    end else if (w_capture) begin
      r_shadow  <= cfg_clamp(i_cfg);
      r_pending <= 1'b1;
    end else if (i_apply && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end
  end

  assign o_cfg_ready = ~r_pending;
  assign o_active    = r_active;

endmodule

// File: rtl/sq_gen.sv
// Programmable glitch-free square-wave generator (HIGH/LOW phase FSM).
// Define SQ_GEN_BURST_EN to add burst_len/burst_done finite-burst mode.
module sq_gen
  import sq_gen_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(6),
  parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(3)
) (
  input  logic    clk_6M,
  input  logic    rst_n,
  sq_gen_if.slave sq
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_low_len;
  logic             w_high_last;
  logic             w_low_last;
  logic             w_apply;
  logic             w_done_nxt;
  logic             w_start_ok;
  logic             w_burst_last;
  logic             r_square;
  logic             r_period_done;
  logic             r_busy;
  logic             w_cfg_ready;
  cfg_t             w_cfg_in;
  cfg_t             w_act;

  assign w_cfg_in.period = sq.cfg_period;
  assign w_cfg_in.high   = sq.cfg_high;

  sq_gen_cfg_reg #(
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH)
  ) u_cfg_reg (
    .clk_6M      (clk_6M),
    .rst_n       (rst_n),
    .i_cfg_valid (sq.cfg_valid),
    .i_cfg       (w_cfg_in),
    .i_apply     (w_apply),
    .o_cfg_ready (w_cfg_ready),
    .o_active    (w_act)
  );

  assign w_low_len   = w_act.period - w_act.high;
  assign w_high_last = (r_phase == w_act.high - CNT_W'(1));
  assign w_low_last  = (r_phase == w_low_len - CNT_W'(1));
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  always_ff @(posedge clk_6M or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_phase       <= '0;
      r_cnt         <= '0;
      r_square      <= 1'b0;
      r_period_done <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_cnt         <= w_cnt_nxt;
      r_square      <= (w_state_nxt == HIGH);
      r_period_done <= w_done_nxt;
      r_busy        <= (w_state_nxt != IDLE);
    end
  end

  // Phase counter restarts on every state change; outputs are decoded from
  // the next state so they line up with it after the edge.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_apply     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_apply = 1'b1;
        if (sq.en && w_start_ok) begin
          w_state_nxt = HIGH;
          w_phase_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      HIGH: begin
        if (w_high_last) begin
          w_state_nxt = LOW;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + CNT_W'(1);
        end
      end
      LOW: begin
        if (w_low_last) begin
          w_apply     = 1'b1;
          w_cnt_nxt   = w_cnt_inc;
          w_phase_nxt = '0;
          w_state_nxt = (sq.en && !w_burst_last) ? HIGH : IDLE;
        end else begin
          w_phase_nxt = r_phase + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = '0;
      end
    endcase
    w_done_nxt = (w_state_nxt == LOW) && (w_phase_nxt == w_low_len - CNT_W'(1));
  end

`ifdef SQ_GEN_BURST_EN
  logic [CNT_W-1:0] r_burst_len;
  logic             r_hold;
  logic             r_burst_done;

  assign w_start_ok   = ~r_hold;
  assign w_burst_last = (r_burst_len != '0) && (w_cnt_inc == r_burst_len);

  // r_hold blocks a restart after a finished burst until en has been low.
  always_ff @(posedge clk_6M or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_len  <= '0;
      r_hold       <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      if (r_state == IDLE && w_state_nxt == HIGH) begin
        r_burst_len <= sq.burst_len;
      end
      if (r_state == LOW && w_low_last && w_burst_last) begin
        r_hold <= 1'b1;
      end else if (!sq.en) begin
        r_hold <= 1'b0;
      end
      r_burst_done <= w_done_nxt && (r_burst_len != '0) &&
                      (w_cnt_nxt + CNT_W'(1) == r_burst_len);
    end
  end

  assign sq.burst_done = r_burst_done;
`else
  assign w_start_ok   = 1'b1;
  assign w_burst_last = 1'b0;
`endif

  assign sq.cfg_ready   = w_cfg_ready;
  assign sq.square      = r_square;
  assign sq.period_done = r_period_done;
  assign sq.period_cnt  = r_cnt;
  assign sq.busy        = r_busy;

endmodule

// File: tb/tb_sq_gen.sv
// Self-checking bench for sq_gen: period-position reference model plus
// directed scenarios with hand-computed expectations.
module tb_sq_gen;
  import sq_gen_pkg::*;

  logic clk_6M = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_6M = ~clk_6M;

  sq_gen_if sq ();
  logic [CNT_W-1:0] tb_blen = '0;
`ifdef SQ_GEN_BURST_EN
  assign sq.burst_len = tb_blen;
`endif

  sq_gen dut (
    .clk_6M (clk_6M),
    .rst_n  (rst_n),
    .sq     (sq)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a period is positions 0..P-1, high while position < H.
  function automatic logic [CNT_W-1:0] clamp_p(input logic [CNT_W-1:0] p);
    return (p < 2) ? CNT_W'(2) : p;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_h(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
    logic [CNT_W-1:0] pc;
    pc = clamp_p(p);
    if (h == 0) return CNT_W'(1);
    if (h >= pc) return pc - CNT_W'(1);
    return h;
  endfunction

  logic             m_run, m_pend, m_hold;
  logic [CNT_W-1:0] m_t, m_cnt, m_P, m_H, m_sP, m_sH, m_blen;
  logic             m_last, m_bnd, m_bend;

  assign m_last = m_run && (m_t == m_P - 1);
  assign m_bnd  = !m_run || m_last;
  assign m_bend = m_last && (m_blen != 0) && ({4'd0, m_cnt} + 32'd1 == {4'd0, m_blen});

  always @(posedge clk_6M or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_pend <= 1'b0; m_hold <= 1'b0;
      m_t <= '0; m_cnt <= '0; m_blen <= '0;
      m_P <= CNT_W'(6); m_H <= CNT_W'(3); m_sP <= CNT_W'(6); m_sH <= CNT_W'(3);
    end else begin
      if (m_bnd && m_pend) begin
        m_P <= m_sP;
        m_H <= m_sH;
      end
      if (sq.cfg_valid && !m_pend) begin
        m_pend <= 1'b1;
        m_sP   <= clamp_p(sq.cfg_period);
        m_sH   <= clamp_h(sq.cfg_period, sq.cfg_high);
      end else if (m_bnd && m_pend) begin
        m_pend <= 1'b0;
      end
      if (!m_run) begin
        if (sq.en && !m_hold) begin
          m_run <= 1'b1; m_t <= '0; m_cnt <= '0; m_blen <= tb_blen;
        end
      end else if (m_last) begin
        m_cnt <= m_cnt + 1;
        m_t   <= '0;
        if (m_bend || !sq.en) m_run <= 1'b0;
      end else begin
        m_t <= m_t + 1;
      end
      if (m_bend) m_hold <= 1'b1;
      else if (!sq.en) m_hold <= 1'b0;
    end
  end

  always @(negedge clk_6M) begin
    if (rst_n) begin
      chk("square", sq.square, m_run && (m_t < m_H));
      chk("period_done", sq.period_done, m_last);
      chk("period_cnt", sq.period_cnt, m_cnt);
      chk("busy", sq.busy, m_run);
      chk("cfg_ready", sq.cfg_ready, !m_pend);
`ifdef SQ_GEN_BURST_EN
      chk("burst_done", sq.burst_done, m_bend);
`endif
    end
  end

  task automatic offer(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
    sq.cfg_valid  = 1'b1;
    sq.cfg_period = p;
    sq.cfg_high   = h;
  endtask

  task automatic wait_done(input int lim, input string name);
    int k = 0;
    do begin
      @(negedge clk_6M);
      k++;
    end while (!sq.period_done && k < lim);
    chk(name, sq.period_done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] sq_pat, dn_pat;
    logic [7:0]  tg_sq, tg_dn;
    logic [6:0]  st_sq, st_busy, st_dn;
    logic [5:0]  r_sq, r_dn;
    int          k, hi;

    sq.en = 1'b0; sq.cfg_valid = 1'b0; sq.cfg_period = '0; sq.cfg_high = '0;
    repeat (3) @(negedge clk_6M);
    chk("rst_square", sq.square, 0);
    chk("rst_done", sq.period_done, 0);
    chk("rst_cnt", sq.period_cnt, 0);
    chk("rst_busy", sq.busy, 0);
    chk("rst_ready", sq.cfg_ready, 1);
    rst_n = 1'b1;

    // Defaults 6/3 after start
    @(negedge clk_6M);
    sq.en = 1'b1;
    sq_pat = 12'b000111000111;
    dn_pat = 12'b100000100000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_6M);
      chk("t1_square", sq.square, sq_pat[i]);
      chk("t1_done", sq.period_done, dn_pat[i]);
    end
    repeat (589) @(negedge clk_6M);
    chk("t1_cnt100", sq.period_cnt, 100);

    // Mid-period reconfiguration to 6000/1500
    repeat (2) @(negedge clk_6M);
    offer(CNT_W'(6000), CNT_W'(1500));
    @(negedge clk_6M);
    chk("t2_ready_low", sq.cfg_ready, 0);
    sq.cfg_valid = 1'b0;
    wait_done(10, "t2_old_boundary");
    chk("t2_ready_at_bnd", sq.cfg_ready, 0);
    k = 0; hi = 0;
    do begin
      @(negedge clk_6M);
      k++;
      if (sq.square) hi++;
    end while (!sq.period_done && k < 7000);
    chk("t2_spacing", k, 6000);
    chk("t2_high", hi, 1500);

    // Clamped 1/0 captured on a boundary; second offer held off
    offer(CNT_W'(1), CNT_W'(0));
    @(negedge clk_6M);
    chk("t3_ready_low", sq.cfg_ready, 0);
    chk("t3_old_square", sq.square, 1);
    offer(CNT_W'(10), CNT_W'(4));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_6M);
      chk("t3_held_off", sq.cfg_ready, 0);
    end
    sq.cfg_valid = 1'b0;
    wait_done(6100, "t3_boundary");
    tg_sq = 8'b01010101;
    tg_dn = 8'b10101010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_6M);
      chk("t3_toggle", sq.square, tg_sq[i]);
      chk("t3_done", sq.period_done, tg_dn[i]);
    end

    // Back to 6/3, then drop en two cycles into a period
    offer(CNT_W'(6), CNT_W'(3));
    @(negedge clk_6M);
    sq.cfg_valid = 1'b0;
    wait_done(10, "t4_apply");
    wait_done(10, "t4_period6");
    repeat (2) @(negedge clk_6M);
    sq.en = 1'b0;
    st_sq   = 7'b0000001;
    st_busy = 7'b0001111;
    st_dn   = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_6M);
      chk("t4_square", sq.square, st_sq[i]);
      chk("t4_busy", sq.busy, st_busy[i]);
      chk("t4_done", sq.period_done, st_dn[i]);
    end

    // Async reset during HIGH with a pending configuration
    @(negedge clk_6M);
    sq.en = 1'b1;
    @(negedge clk_6M);
    chk("t5_square_high", sq.square, 1);
    offer(CNT_W'(10), CNT_W'(5));
    @(negedge clk_6M);
    chk("t5_pending", sq.cfg_ready, 0);
    sq.cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_square_async", sq.square, 0);
    chk("t5_busy_async", sq.busy, 0);
    repeat (2) @(negedge clk_6M);
    chk("t5_ready", sq.cfg_ready, 1);
    chk("t5_cnt", sq.period_cnt, 0);
    rst_n = 1'b1;
    r_sq = 6'b000111;
    r_dn = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_6M);
      chk("t5_square", sq.square, r_sq[i]);
      chk("t5_done", sq.period_done, r_dn[i]);
    end
    repeat (6) @(negedge clk_6M);

`ifdef SQ_GEN_BURST_EN
    begin
      int pulses, dones, bursts;
      logic prev;
      sq.en = 1'b0;
      k = 0;
      do begin
        @(negedge clk_6M);
        k++;
      end while (sq.busy && k < 20);
      chk("t6_idle", sq.busy, 0);
      tb_blen = CNT_W'(5);
      sq.en = 1'b1;
      pulses = 0; dones = 0; bursts = 0; prev = 1'b0;
      for (int i = 0; i < 45; i++) begin
        @(negedge clk_6M);
        if (sq.square && !prev) pulses++;
        if (sq.period_done) dones++;
        if (sq.burst_done) bursts++;
        prev = sq.square;
      end
      chk("t6_pulses", pulses, 5);
      chk("t6_dones", dones, 5);
      chk("t6_burst_done", bursts, 1);
      chk("t6_busy_dropped", sq.busy, 0);
      chk("t6_cnt", sq.period_cnt, 5);
      tb_blen = '0;
    end
`endif

    sq.en = 1'b0;
    repeat (10) @(negedge clk_6M);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
